// File: rtl/pmod_clock_gen.sv
// NUM_CH-channel square-wave divider with runtime half-period updates through a one-deep config slot.
// Define CLKGEN_SYNC_EN to add the SYNC input, which realigns every channel to phase zero.
module pmod_clock_gen #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 24,
    parameter int DIV_INIT = 50
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
`ifdef CLKGEN_SYNC_EN
    input  logic              SYNC,
`endif
    input  logic              CFG_VALID,
    output logic              CFG_READY,
    input  logic [3:0]        CFG_CHAN,
    input  logic [CNT_W-1:0]  CFG_DIV,
    output logic [NUM_CH-1:0] P_OUT,
    output logic [NUM_CH-1:0] TICK
);

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [CNT_W-1:0]  div_q [NUM_CH];
    logic [CNT_W-1:0]  div_d [NUM_CH];
    logic [NUM_CH-1:0] p_q, p_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic              pend_q, pend_d;
    logic [3:0]        pend_chan_q, pend_chan_d;
    logic [CNT_W-1:0]  pend_div_q, pend_div_d;

    logic [NUM_CH-1:0] bnd_w;
    logic [NUM_CH-1:0] hit_w;
    logic              sync_w;
    logic              cfg_fire_w;
    logic              chan_ok_w;
    logic              apply_any;

`ifdef CLKGEN_SYNC_EN
    assign sync_w = SYNC;
`else
    assign sync_w = 1'b0;
`endif

    // Handshake: a request transfers on any rising edge where CFG_VALID && CFG_READY.
    // READY is low during reset and whenever the single pending slot is occupied.
    assign CFG_READY  = !pend_q && !RST;
    assign cfg_fire_w = CFG_VALID && CFG_READY;
    assign chan_ok_w  = (int'(CFG_CHAN) < NUM_CH);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign bnd_w[g] = (div_q[g] != '0) && (cnt_q[g] == div_q[g] - CNT_W'(1));
        assign hit_w[g] = pend_q && (pend_chan_q == 4'(g));
    end

    always_comb begin
        cnt_d       = cnt_q;
        div_d       = div_q;
        p_d         = p_q;
        tick_d      = '0;
        pend_d      = pend_q;
        pend_chan_d = pend_chan_q;
        pend_div_d  = pend_div_q;
        apply_any   = 1'b0;

        for (int k = 0; k < NUM_CH; k++) begin
            if (sync_w) begin
                cnt_d[k] = '0;
                p_d[k]   = 1'b0;
                if (hit_w[k]) begin
                    div_d[k]  = pend_div_q;
                    apply_any = 1'b1;
                end
            end else if (hit_w[k] && (div_q[k] == '0 || !EN || bnd_w[k])) begin
                // Update lands on a boundary, so the output never shows a short half-period.
                div_d[k]  = pend_div_q;
                cnt_d[k]  = '0;
                apply_any = 1'b1;
                if (!EN) begin
                    p_d[k] = p_q[k];
                end else if (pend_div_q == '0) begin
                    p_d[k] = 1'b0;
                end else if (div_q[k] != '0) begin
                    p_d[k]    = ~p_q[k];
                    tick_d[k] = 1'b1;
                end
            end else if (EN) begin
                if (div_q[k] == '0) begin
                    cnt_d[k] = '0;
                    p_d[k]   = 1'b0;
                end else if (bnd_w[k]) begin
                    cnt_d[k]  = '0;
                    p_d[k]    = ~p_q[k];
                    tick_d[k] = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
            end
        end

        if (apply_any) begin
            pend_d = 1'b0;
        end
        // Out-of-range channels are consumed without occupying the slot.
        if (cfg_fire_w && chan_ok_w) begin
            pend_d      = 1'b1;
            pend_chan_d = CFG_CHAN;
            pend_div_d  = CFG_DIV;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_q[k] <= '0;
                div_q[k] <= CNT_W'(DIV_INIT);
            end
            p_q         <= '0;
            tick_q      <= '0;
            pend_q      <= 1'b0;
            pend_chan_q <= '0;
            pend_div_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            p_q         <= p_d;
            tick_q      <= tick_d;
            pend_q      <= pend_d;
            pend_chan_q <= pend_chan_d;
            pend_div_q  <= pend_div_d;
        end
    end

    assign P_OUT = p_q;
    assign TICK  = tick_q;

endmodule
